// File: rtl/hdd_pkg.sv
// Shared types and constants for the HDD-to-SD bridge.
package hdd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        XFER
    } hdd_state_t;

    localparam int SECTOR_BYTES = 512;

endpackage

// File: rtl/hdd_sector_buf.sv
// 512x8 true dual-port sector buffer: A = SD side, B = CPU side.
// A same-address write on both ports stores the SD data.
module hdd_sector_buf
    import hdd_pkg::*;
#(
    parameter int AW = 9
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic [AW-1:0] addr_a,
    input  logic [7:0]    din_a,
    input  logic          we_a,
    output logic [7:0]    dout_a,
    input  logic [AW-1:0] addr_b,
    input  logic [7:0]    din_b,
    input  logic          we_b,
    output logic [7:0]    dout_b
);

    logic [7:0] mem [SECTOR_BYTES];
    logic       collide;

    assign collide = we_a && we_b && (addr_a == addr_b);

    always_ff @(posedge clk_sys) begin
        if (we_a)
            mem[addr_a] <= din_a;
        if (we_b && !collide)
            mem[addr_b] <= din_b;
    end

    // Read-during-write returns whatever this cycle actually stores.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dout_a <= '0;
            dout_b <= '0;
        end else begin
            dout_a <= we_a ? din_a : mem[addr_a];
            if (collide)
                dout_b <= din_a;
            else if (we_b)
                dout_b <= din_b;
            else
                dout_b <= mem[addr_b];
        end
    end

endmodule

// File: rtl/hdd_sd_bridge.sv
// Turns apple2 HDD read/write pulses into SD slot requests, stalls the CPU
// for the transfer, tracks mount state and owns the sector buffer.
module hdd_sd_bridge
    import hdd_pkg::*;
#(
    parameter logic [23:0] TIMEOUT = 24'd2_000_000,
    parameter int          BUF_AW  = 9
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic [15:0]       hdd_sector,
    input  logic              hdd_read,
    input  logic              hdd_write,
    input  logic              img_mounted,
    input  logic              img_readonly,
    input  logic [63:0]       img_size,
    output logic              hdd_mounted,
    output logic              hdd_protect,
    output logic              cpu_wait,
    output logic              err,
    output logic [31:0]       sd_lba,
    output logic              sd_rd,
    output logic              sd_wr,
    input  logic              sd_ack,
    input  logic [BUF_AW-1:0] sd_buff_addr,
    input  logic [7:0]        sd_buff_dout,
    input  logic              sd_buff_wr,
    output logic [7:0]        sd_buff_din,
    input  logic [BUF_AW-1:0] hdd_ram_addr,
    input  logic [7:0]        hdd_ram_di,
    input  logic              hdd_ram_we,
    output logic [7:0]        hdd_ram_do
);

    hdd_state_t  state;
    logic        rd_pend, wr_pend, is_wr, old_ack;
    logic [23:0] cnt;
    logic        rd_req, wr_req, ack_rise, ack_fall;

    // A pulse arriving this cycle is already visible to the IDLE decision.
    assign rd_req   = rd_pend | hdd_read;
    assign wr_req   = wr_pend | hdd_write;
    assign ack_rise = sd_ack & ~old_ack;
    assign ack_fall = ~sd_ack & old_ack;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            rd_pend     <= 1'b0;
            wr_pend     <= 1'b0;
            is_wr       <= 1'b0;
            old_ack     <= 1'b0;
            cnt         <= '0;
            hdd_mounted <= 1'b0;
            hdd_protect <= 1'b0;
            cpu_wait    <= 1'b0;
            err         <= 1'b0;
            sd_lba      <= '0;
            sd_rd       <= 1'b0;
            sd_wr       <= 1'b0;
        end else begin
            old_ack <= sd_ack;
            rd_pend <= rd_req;
            wr_pend <= wr_req;
            if (img_mounted) begin
                hdd_mounted <= |img_size;
                hdd_protect <= img_readonly;
            end
            case (state)
                IDLE: if (rd_req || wr_req) begin
                    if (!hdd_mounted) begin
                        err <= 1'b1;
                        if (rd_req) rd_pend <= 1'b0;
                        else        wr_pend <= 1'b0;
                    end else if (!rd_req && hdd_protect) begin
                        err     <= 1'b1;
                        wr_pend <= 1'b0;
                    end else begin
                        sd_lba   <= {16'b0, hdd_sector};
                        sd_rd    <= rd_req;
                        sd_wr    <= ~rd_req;
                        is_wr    <= ~rd_req;
                        cpu_wait <= 1'b1;
                        err      <= 1'b0;
                        cnt      <= '0;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (ack_rise || cnt == TIMEOUT - 24'd1) begin
                        sd_rd <= 1'b0;
                        sd_wr <= 1'b0;
                        // keep a fresh pulse of the same kind that lands now
                        if (is_wr) wr_pend <= hdd_write;
                        else       rd_pend <= hdd_read;
                        if (ack_rise) begin
                            state <= XFER;
                        end else begin
                            err      <= 1'b1;
                            cpu_wait <= 1'b0;
                            state    <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 24'd1;
                    end
                end
                XFER: if (ack_fall) begin
                    cpu_wait <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    hdd_sector_buf #(.AW(BUF_AW)) u_buf (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .addr_a  (sd_buff_addr),
        .din_a   (sd_buff_dout),
        .we_a    (sd_buff_wr & sd_ack),
        .dout_a  (sd_buff_din),
        .addr_b  (hdd_ram_addr),
        .din_b   (hdd_ram_di),
        .we_b    (hdd_ram_we),
        .dout_b  (hdd_ram_do)
    );

endmodule

// File: tb/tb_hdd_sd_bridge.sv
// Directed bench for hdd_sd_bridge with a short timeout.
module tb_hdd_sd_bridge;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [15:0] hdd_sector;
    logic        hdd_read, hdd_write;
    logic        img_mounted, img_readonly;
    logic [63:0] img_size;
    logic        hdd_mounted, hdd_protect, cpu_wait, err;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr, sd_ack;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_buff_dout;
    logic        sd_buff_wr;
    logic [7:0]  sd_buff_din;
    logic [8:0]  hdd_ram_addr;
    logic [7:0]  hdd_ram_di;
    logic        hdd_ram_we;
    logic [7:0]  hdd_ram_do;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_sys = ~clk_sys;

    hdd_sd_bridge #(.TIMEOUT(24'd16), .BUF_AW(9)) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .hdd_sector   (hdd_sector),
        .hdd_read     (hdd_read),
        .hdd_write    (hdd_write),
        .img_mounted  (img_mounted),
        .img_readonly (img_readonly),
        .img_size     (img_size),
        .hdd_mounted  (hdd_mounted),
        .hdd_protect  (hdd_protect),
        .cpu_wait     (cpu_wait),
        .err          (err),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_addr (sd_buff_addr),
        .sd_buff_dout (sd_buff_dout),
        .sd_buff_wr   (sd_buff_wr),
        .sd_buff_din  (sd_buff_din),
        .hdd_ram_addr (hdd_ram_addr),
        .hdd_ram_di   (hdd_ram_di),
        .hdd_ram_we   (hdd_ram_we),
        .hdd_ram_do   (hdd_ram_do)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // advance one edge; outputs are then sampled 1 ns after it
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    function automatic logic [7:0] pat(input int i);
        logic [7:0] v;
        v = 8'(i * 7 + 3) ^ 8'h5A;
        return v;
    endfunction

    task automatic mount(input logic [63:0] size, input logic ro);
        img_mounted  = 1'b1;
        img_size     = size;
        img_readonly = ro;
        tick();
        img_mounted  = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; hdd_sector = '0; hdd_read = 0; hdd_write = 0;
        img_mounted = 0; img_readonly = 0; img_size = '0; sd_ack = 0;
        sd_buff_addr = '0; sd_buff_dout = '0; sd_buff_wr = 0;
        hdd_ram_addr = '0; hdd_ram_di = '0; hdd_ram_we = 0;
        #3;
        chk("rst_sd_rd", sd_rd, 0);
        chk("rst_cpu_wait", cpu_wait, 0);
        chk("rst_err", err, 0);
        chk("rst_mounted", hdd_mounted, 0);
        chk("rst_lba", sd_lba, 0);
        tick(2);
        reset_n = 1'b1;
        tick();

        // 1: read of sector 0x123 with a full 512-byte transfer
        mount(64'd1048576, 1'b0);
        chk("t1_mounted", hdd_mounted, 1);
        chk("t1_protect", hdd_protect, 0);
        hdd_read = 1; hdd_sector = 16'h0123;
        tick();
        hdd_read = 0;
        chk("t1_sd_rd", sd_rd, 1);
        chk("t1_cpu_wait", cpu_wait, 1);
        chk("t1_lba", sd_lba, 32'h0000_0123);
        tick(2);
        sd_ack = 1;
        tick();
        chk("t1_rd_drop", sd_rd, 0);
        chk("t1_wait_held", cpu_wait, 1);
        for (int i = 0; i < 512; i++) begin
            sd_buff_addr = 9'(i); sd_buff_dout = pat(i); sd_buff_wr = 1;
            tick();
        end
        sd_buff_wr = 0;
        chk("t1_wait_before_fall", cpu_wait, 1);
        sd_ack = 0;
        tick();
        chk("t1_wait_drop", cpu_wait, 0);
        for (int i = 0; i < 512; i += 73) begin
            hdd_ram_addr = 9'(i);
            tick();
            chk("t1_buf_rd", hdd_ram_do, pat(i));
        end
        hdd_ram_addr = 9'h1FF;
        tick();
        chk("t1_buf_last", hdd_ram_do, pat(511));
        hdd_ram_addr = 9'd5; hdd_ram_di = 8'hC3; hdd_ram_we = 1;
        tick();
        hdd_ram_we = 0; sd_buff_addr = 9'd5;
        tick();
        chk("t1_cpu_to_sd", sd_buff_din, 8'hC3);

        // 2: simultaneous read + write, read first then write on same LBA
        hdd_read = 1; hdd_write = 1; hdd_sector = 16'h0042;
        tick();
        hdd_read = 0; hdd_write = 0;
        chk("t2_rd_first", sd_rd, 1);
        chk("t2_no_wr_yet", sd_wr, 0);
        sd_ack = 1; tick();
        sd_ack = 0; tick();
        chk("t2_rd_done", cpu_wait, 0);
        tick();
        chk("t2_wr_start", sd_wr, 1);
        chk("t2_wr_lba", sd_lba, 32'h0000_0042);
        chk("t2_wr_wait", cpu_wait, 1);
        sd_ack = 1; tick();
        sd_ack = 0; tick();
        chk("t2_wr_done", cpu_wait, 0);
        chk("t2_wr_low", sd_wr, 0);

        // 3: write to a read-only image is refused, next read clears err
        mount(64'd1048576, 1'b1);
        chk("t3_protect", hdd_protect, 1);
        hdd_write = 1;
        tick();
        hdd_write = 0;
        chk("t3_no_wr", sd_wr, 0);
        chk("t3_no_wait", cpu_wait, 0);
        chk("t3_err", err, 1);
        tick();
        chk("t3_still_no_wr", sd_wr, 0);
        hdd_read = 1; hdd_sector = 16'h0007;
        tick();
        hdd_read = 0;
        chk("t3_rd_ok", sd_rd, 1);
        chk("t3_err_clr", err, 0);
        sd_ack = 1; tick();
        sd_ack = 0; tick();
        chk("t3_done", cpu_wait, 0);

        // 4: no ack, timeout of 16 cycles
        hdd_read = 1;
        tick();
        hdd_read = 0;
        chk("t4_rd", sd_rd, 1);
        tick(15);
        chk("t4_rd_at15", sd_rd, 1);
        tick();
        chk("t4_rd_at16", sd_rd, 0);
        chk("t4_err", err, 1);
        chk("t4_wait", cpu_wait, 0);

        // 5: async reset in the middle of a transfer
        hdd_read = 1;
        tick();
        hdd_read = 0;
        sd_ack = 1;
        tick();
        chk("t5_xfer_wait", cpu_wait, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("t5_rst_rd", sd_rd, 0);
        chk("t5_rst_wr", sd_wr, 0);
        chk("t5_rst_wait", cpu_wait, 0);
        chk("t5_rst_err", err, 0);
        chk("t5_rst_mnt", hdd_mounted, 0);
        tick();
        reset_n = 1'b1;
        tick();
        sd_ack = 0;
        tick(2);
        chk("t5_late_wait", cpu_wait, 0);
        chk("t5_late_rd", sd_rd, 0);
        chk("t5_late_err", err, 0);

        // 6: empty image, then SD/CPU write collision at 0x1FF
        mount(64'd0, 1'b0);
        chk("t6_not_mnt", hdd_mounted, 0);
        hdd_read = 1;
        tick();
        hdd_read = 0;
        chk("t6_no_rd", sd_rd, 0);
        chk("t6_no_wait", cpu_wait, 0);
        chk("t6_err", err, 1);
        sd_ack = 1;
        sd_buff_addr = 9'h1FF; sd_buff_dout = 8'hAA; sd_buff_wr = 1;
        hdd_ram_addr = 9'h1FF; hdd_ram_di = 8'h55; hdd_ram_we = 1;
        tick();
        sd_buff_wr = 0; hdd_ram_we = 0; sd_ack = 0;
        tick();
        chk("t6_collide", hdd_ram_do, 8'hAA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
